seq_recognizer: RTL and testbench

- Parametrised symbol-sequence recognizer.
- Accepts a stream of WIDTH-bit symbols (ASCII by default) under a valid strobe and compares the last LEN accepted symbols against a run-time programmable pattern.
- Emits a one-cycle registered match pulse and keeps a saturating match count.
- Sits between the keyboard/stdin symbol source and any consumer needing "magic sequence" detection; replaces the fixed 3-symbol, ungated recognizer.

---
 rtl/seq_recog_pkg.sv | 24 ++
 rtl/seq_history.sv | 38 +++
 rtl/seq_recognizer.sv | 98 +++++++++
 tb/tb_seq_recognizer.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/seq_recog_pkg.sv
// Shared defaults and fill-level state type for the symbol-sequence recognizer.
// No logic; purely constants, types and a helper to classify the fill level.
package seq_recog_pkg;

  localparam int DEF_WIDTH = 7;
  localparam int DEF_LEN   = 3;
  localparam int DEF_CNT_W = 8;

  // "123" in 7-bit ASCII, first expected symbol in the MS slice
  localparam logic [DEF_LEN*DEF_WIDTH-1:0] DEF_RESET_PAT = {7'h31, 7'h32, 7'h33};

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    FILLING = 2'd1,
    FULL    = 2'd2
  } fill_state_t;

  function automatic fill_state_t fill_state(input int fill, input int len);
    if (fill == 0) return EMPTY;
    if (fill >= len) return FULL;
    return FILLING;
  endfunction

endpackage

// File: rtl/seq_history.sv
// LEN-deep WIDTH-bit symbol shift register; slot 0 (oldest) sits in the MS slice.
// Single-cycle update, flush beats enable; o_shift is the would-be contents after a shift.
module seq_history #(
  parameter int WIDTH = 7,
  parameter int LEN   = 3
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_flush,
  input  logic                   i_en,
  input  logic [WIDTH-1:0]       i_sym,
  output logic [LEN*WIDTH-1:0]   o_shift
);

  logic [LEN*WIDTH-1:0] r_hist;
  logic [LEN*WIDTH-1:0] w_shift;

  generate
    if (LEN == 1) begin : g_one
      assign w_shift = i_sym;
    end else begin : g_multi
      assign w_shift = {r_hist[(LEN-1)*WIDTH-1:0], i_sym};
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hist <= '0;
    end else if (i_flush) begin
      r_hist <= '0;
    end else if (i_en) begin
      r_hist <= w_shift;
    end
  end

  assign o_shift = w_shift;

endmodule

// File: rtl/seq_recognizer.sv
// Matches the last LEN accepted symbols against a programmable pattern; counts hits.
// Match pulse one cycle after the accepting edge; no backpressure, every valid symbol is taken.
module seq_recognizer
  import seq_recog_pkg::*;
#(
  parameter int                          WIDTH     = DEF_WIDTH,
  parameter int                          LEN       = DEF_LEN,
  parameter int                          CNT_W     = DEF_CNT_W,
  parameter logic [LEN*WIDTH-1:0]        RESET_PAT = DEF_RESET_PAT
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  in_valid,
  input  logic [WIDTH-1:0]                      in_sym,
  input  logic                                  prog_en,
  input  logic [((LEN > 1) ? $clog2(LEN) : 1)-1:0] prog_idx,
  input  logic [WIDTH-1:0]                      prog_sym,
  input  logic                                  overlap,
  input  logic                                  clear,
  output logic                                  match,
  output logic [CNT_W-1:0]                      match_count,
  output logic [$clog2(LEN+1)-1:0]              fill
);

  localparam int IDX_W  = (LEN > 1) ? $clog2(LEN) : 1;
  localparam int FILL_W = $clog2(LEN + 1);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(LEN);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

  logic [WIDTH-1:0]      r_pat [LEN];
  logic [LEN*WIDTH-1:0]  w_pat;
  logic [LEN*WIDTH-1:0]  w_shift;
  logic [FILL_W-1:0]     r_fill;
  logic [FILL_W-1:0]     w_fill_inc;
  logic                  r_match;
  logic [CNT_W-1:0]      r_count;
  logic                  w_hit;
  fill_state_t           w_fill_state;

  for (genvar g = 0; g < LEN; g++) begin : g_pat
    assign w_pat[(LEN-1-g)*WIDTH +: WIDTH] = r_pat[g];
  end

  // Any flush (clear or reprogram) wins over a concurrent accept inside the history
  seq_history #(
    .WIDTH (WIDTH),
    .LEN   (LEN)
  ) u_history (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_flush (clear | prog_en),
    .i_en    (in_valid),
    .i_sym   (in_sym),
    .o_shift (w_shift)
  );

  assign w_fill_inc = (r_fill == FILL_FULL) ? r_fill : r_fill + FILL_W'(1);
  assign w_hit      = (w_fill_inc == FILL_FULL) && (w_shift == w_pat);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LEN; i++) begin
        r_pat[i] <= RESET_PAT[(LEN-1-i)*WIDTH +: WIDTH];
      end
      r_fill  <= '0;
      r_match <= 1'b0;
      r_count <= '0;
    end else if (clear) begin
      r_fill  <= '0;
      r_match <= 1'b0;
      r_count <= '0;
    end else if (prog_en) begin
      for (int i = 0; i < LEN; i++) begin
        if (prog_idx == IDX_W'(i)) r_pat[i] <= prog_sym;
      end
      r_fill  <= '0;
      r_match <= 1'b0;
    end else if (in_valid) begin
      r_match <= w_hit;
      if (w_hit && (r_count != CNT_MAX)) r_count <= r_count + CNT_W'(1);
      r_fill  <= (w_hit && !overlap) ? '0 : w_fill_inc;
    end else begin
      r_match <= 1'b0;
    end
  end

  assign w_fill_state = fill_state(32'(r_fill), LEN);

  // A hit leaves the history either still full (overlap) or flushed, never part-filled
  a_hit_leaves_full_or_empty: assert property (
    @(posedge clk) disable iff (!rst_n) r_match |-> (w_fill_state != FILLING)
  );

  assign match       = r_match;
  assign match_count = r_count;
  assign fill        = r_fill;

endmodule

// File: tb/tb_seq_recognizer.sv
// Directed bench for seq_recognizer: default 3-symbol instance plus a LEN=2, CNT_W=2 instance.
// Expected outputs are queued as each step is driven and checked one edge later.
module tb_seq_recognizer;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic       a_in_valid, a_prog_en, a_overlap, a_clear;
  logic [6:0] a_in_sym, a_prog_sym;
  logic [1:0] a_prog_idx;
  logic       a_match;
  logic [7:0] a_match_count;
  logic [1:0] a_fill;

  logic       b_in_valid, b_prog_en, b_overlap, b_clear;
  logic [6:0] b_in_sym, b_prog_sym;
  logic [0:0] b_prog_idx;
  logic       b_match;
  logic [1:0] b_match_count;
  logic [1:0] b_fill;

  seq_recognizer u_dut_a (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (a_in_valid),
    .in_sym      (a_in_sym),
    .prog_en     (a_prog_en),
    .prog_idx    (a_prog_idx),
    .prog_sym    (a_prog_sym),
    .overlap     (a_overlap),
    .clear       (a_clear),
    .match       (a_match),
    .match_count (a_match_count),
    .fill        (a_fill)
  );

  seq_recognizer #(
    .WIDTH     (7),
    .LEN       (2),
    .CNT_W     (2),
    .RESET_PAT ({7'h41, 7'h42})
  ) u_dut_b (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (b_in_valid),
    .in_sym      (b_in_sym),
    .prog_en     (b_prog_en),
    .prog_idx    (b_prog_idx),
    .prog_sym    (b_prog_sym),
    .overlap     (b_overlap),
    .clear       (b_clear),
    .match       (b_match),
    .match_count (b_match_count),
    .fill        (b_fill)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [10:0] exp_q [$];
  string       tag_q [$];
  bit          sel_q [$];

  task automatic push_exp(input bit sb, input logic em, input int ec, input int ef, input string tag);
    exp_q.push_back({em, 8'(ec), 2'(ef)});
    tag_q.push_back(tag);
    sel_q.push_back(sb);
  endtask

  task automatic pop_check();
    logic [10:0] e;
    logic [10:0] o;
    string       t;
    bit          sb;
    e  = exp_q.pop_front();
    t  = tag_q.pop_front();
    sb = sel_q.pop_front();
    o  = sb ? {b_match, 6'b0, b_match_count, b_fill} : {a_match, a_match_count, a_fill};
    n_checks++;
    assert (o[10] === e[10]) else begin
      n_fail++;
      $error("FAIL %s.match got %0b expected %0b", t, o[10], e[10]);
    end
    n_checks++;
    assert (o[9:2] === e[9:2]) else begin
      n_fail++;
      $error("FAIL %s.count got %0d expected %0d", t, o[9:2], e[9:2]);
    end
    n_checks++;
    assert (o[1:0] === e[1:0]) else begin
      n_fail++;
      $error("FAIL %s.fill got %0d expected %0d", t, o[1:0], e[1:0]);
    end
  endtask

  task automatic chk(input bit sb, input logic em, input int ec, input int ef, input string tag);
    push_exp(sb, em, ec, ef, tag);
    pop_check();
  endtask

  task automatic cyc(input bit sb, input logic v, input logic [6:0] s, input logic pe,
                     input logic [1:0] pi, input logic [6:0] ps, input logic ov, input logic clr,
                     input logic em, input int ec, input int ef, input string tag);
    a_in_valid = sb ? 1'b0 : v;   b_in_valid = sb ? v : 1'b0;
    a_in_sym   = sb ? 7'h0 : s;   b_in_sym   = sb ? s : 7'h0;
    a_prog_en  = sb ? 1'b0 : pe;  b_prog_en  = sb ? pe : 1'b0;
    a_prog_idx = sb ? 2'd0 : pi;  b_prog_idx = sb ? pi[0] : 1'b0;
    a_prog_sym = sb ? 7'h0 : ps;  b_prog_sym = sb ? ps : 7'h0;
    a_overlap  = sb ? 1'b0 : ov;  b_overlap  = sb ? ov : 1'b0;
    a_clear    = sb ? 1'b0 : clr; b_clear    = sb ? clr : 1'b0;
    push_exp(sb, em, ec, ef, tag);
    @(posedge clk);
    #1;
    pop_check();
  endtask

  task automatic sym(input bit sb, input logic [6:0] s, input logic ov,
                     input logic em, input int ec, input int ef, input string tag);
    cyc(sb, 1'b1, s, 1'b0, 2'd0, 7'h0, ov, 1'b0, em, ec, ef, tag);
  endtask

  task automatic idle(input bit sb, input logic em, input int ec, input int ef, input string tag);
    cyc(sb, 1'b0, 7'h0, 1'b0, 2'd0, 7'h0, 1'b0, 1'b0, em, ec, ef, tag);
  endtask

  localparam bit A = 1'b0;
  localparam bit B = 1'b1;

  initial begin
    rst_n = 1'b0;
    a_in_valid = 0; a_in_sym = 0; a_prog_en = 0; a_prog_idx = 0; a_prog_sym = 0; a_overlap = 0; a_clear = 0;
    b_in_valid = 0; b_in_sym = 0; b_prog_en = 0; b_prog_idx = 0; b_prog_sym = 0; b_overlap = 0; b_clear = 0;
    #2;
    chk(A, 0, 0, 0, "rst_a");
    chk(B, 0, 0, 0, "rst_b");
    @(posedge clk); #1;
    rst_n = 1'b1;

    // "123" on default pattern, non-overlapping
    sym(A, 7'h31, 0, 0, 0, 1, "t1_s1");
    sym(A, 7'h32, 0, 0, 0, 2, "t1_s2");
    sym(A, 7'h33, 0, 1, 1, 0, "t1_s3");

    // "12x123" with idle gaps: a single hit on the final '3'
    sym (A, 7'h31, 0, 0, 1, 1, "t2_1");
    idle(A,        0, 1, 1, "t2_g1");
    sym (A, 7'h32, 0, 0, 1, 2, "t2_2");
    idle(A,        0, 1, 2, "t2_g2");
    sym (A, 7'h78, 0, 0, 1, 3, "t2_x");
    idle(A,        0, 1, 3, "t2_g3");
    sym (A, 7'h31, 0, 0, 1, 3, "t2_1b");
    idle(A,        0, 1, 3, "t2_g4");
    sym (A, 7'h32, 0, 0, 1, 3, "t2_2b");
    idle(A,        0, 1, 3, "t2_g5");
    sym (A, 7'h33, 0, 1, 2, 0, "t2_3");
    idle(A,        0, 2, 0, "t2_g6");

    // clear beats prog_en and in_valid; pattern must still be "123"
    cyc(A, 1, 7'h31, 1, 2'd2, 7'h7a, 0, 1, 0, 0, 0, "t3_clr");
    sym(A, 7'h31, 0, 0, 0, 1, "t3_1");
    sym(A, 7'h32, 0, 0, 0, 2, "t3_2");
    sym(A, 7'h33, 0, 1, 1, 0, "t3_3");

    // reprogram slot 2 to '4' with a concurrent '3' that would have completed "123"
    sym(A, 7'h31, 0, 0, 1, 1, "t4_1");
    sym(A, 7'h32, 0, 0, 1, 2, "t4_2");
    cyc(A, 1, 7'h33, 1, 2'd2, 7'h34, 0, 0, 0, 1, 0, "t4_prog");
    sym(A, 7'h33, 0, 0, 1, 1, "t4_3");
    sym(A, 7'h31, 0, 0, 1, 2, "t4_1b");
    sym(A, 7'h32, 0, 0, 1, 3, "t4_2b");
    sym(A, 7'h34, 0, 1, 2, 0, "t4_4");

    // out-of-range slot: write ignored, fill still flushed
    sym(A, 7'h31, 0, 0, 2, 1, "t5_pre");
    cyc(A, 0, 7'h00, 1, 2'd3, 7'h71, 0, 0, 0, 2, 0, "t5_prog3");
    sym(A, 7'h31, 0, 0, 2, 1, "t5_1");
    sym(A, 7'h32, 0, 0, 2, 2, "t5_2");
    sym(A, 7'h34, 0, 1, 3, 0, "t5_4");

    // overlap=1 keeps fill at LEN after a hit
    sym(A, 7'h31, 1, 0, 3, 1, "t6_1");
    sym(A, 7'h32, 1, 0, 3, 2, "t6_2");
    sym(A, 7'h34, 1, 1, 4, 3, "t6_4");
    sym(A, 7'h31, 1, 0, 4, 3, "t6_1b");

    // async reset mid-stream; the pattern returns to "123"
    sym(A, 7'h31, 0, 0, 4, 3, "t7_1");
    sym(A, 7'h32, 0, 0, 4, 3, "t7_2");
    rst_n = 1'b0;
    #2;
    chk(A, 0, 0, 0, "t7_async");
    rst_n = 1'b1;
    sym(A, 7'h33, 0, 0, 0, 1, "t7_3");
    sym(A, 7'h31, 0, 0, 0, 2, "t7_1b");
    sym(A, 7'h32, 0, 0, 0, 2 + 1, "t7_2b");
    sym(A, 7'h33, 0, 1, 1, 0, "t7_3b");

    // LEN=2 instance: reset pattern "AB", then program "11"
    sym(B, 7'h41, 0, 0, 0, 1, "b_A");
    sym(B, 7'h42, 0, 1, 1, 0, "b_B");
    cyc(B, 0, 7'h00, 1, 2'd0, 7'h31, 0, 0, 0, 1, 0, "b_prog0");
    cyc(B, 0, 7'h00, 1, 2'd1, 7'h31, 0, 0, 0, 1, 0, "b_prog1");

    cyc(B, 0, 7'h00, 0, 2'd0, 7'h00, 0, 1, 0, 0, 0, "b_clr1");
    sym(B, 7'h31, 1, 0, 0, 1, "b_ov_1");
    sym(B, 7'h31, 1, 1, 1, 2, "b_ov_2");
    sym(B, 7'h31, 1, 1, 2, 2, "b_ov_3");

    cyc(B, 0, 7'h00, 0, 2'd0, 7'h00, 0, 1, 0, 0, 0, "b_clr2");
    sym(B, 7'h31, 0, 0, 0, 1, "b_no_1");
    sym(B, 7'h31, 0, 1, 1, 0, "b_no_2");
    sym(B, 7'h31, 0, 0, 1, 1, "b_no_3");

    // 2-bit counter saturates at 3 while match keeps pulsing
    cyc(B, 0, 7'h00, 0, 2'd0, 7'h00, 0, 1, 0, 0, 0, "b_clr3");
    sym(B, 7'h31, 1, 0, 0, 1, "b_sat_1");
    sym(B, 7'h31, 1, 1, 1, 2, "b_sat_2");
    sym(B, 7'h31, 1, 1, 2, 2, "b_sat_3");
    sym(B, 7'h31, 1, 1, 3, 2, "b_sat_4");
    for (int i = 5; i <= 8; i++) begin
      sym(B, 7'h31, 1, 1, 3, 2, $sformatf("b_sat_%0d", i));
    end
    idle(B, 0, 3, 2, "b_sat_idle");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
